mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single instruction/data memory port between the IF fetch path and the MEM stage.
//  Grants one requester at a time, with MEM priority and an IF anti-starvation counter.
//  Registers all memory-side outputs and returns read data with a one-cycle ack pulse.
//  Supports an IF kill for jump purges: the in-flight fetch completes but its result is dropped.
// PARAMETERS
//  ADDR_L      32  address width
//  DATA_L      32  data width
//  STARVE_MAX  4   consecutive MEM grants allowed while if_re is waiting (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  if_re      in   1       IF read request, level, held until if_rack
//  if_addr    in   ADDR_L  IF fetch address
//  if_rlen    in   2       IF read length (0 byte, 1 half, 3 word)
//  if_kill    in   1       discard the current or pending IF result (jump purge)
//  if_rack    out  1       IF ack, 1-cycle pulse
//  if_data    out  DATA_L  IF read data, valid while if_rack=1
//  mem_re     in   1       MEM read request, level
//  mem_we     in   1       MEM write request, level
//  mem_addr   in   ADDR_L  MEM address
//  mem_len    in   2       MEM access length (encoding as if_rlen)
//  mem_wdata  in   DATA_L  MEM write data
//  mem_ack    out  1       MEM ack, 1-cycle pulse
//  mem_rdata  out  DATA_L  MEM read data, valid while mem_ack=1
//  ram_re     out  1       memory read strobe, level
//  ram_we     out  1       memory write strobe, level
//  ram_addr   out  ADDR_L  memory address
//  ram_len    out  2       memory access length
//  ram_wdata  out  DATA_L  memory write data
//  ram_ack    in   1       memory done; ram_rdata valid in the same cycle
//  ram_rdata  in   DATA_L  memory read data
//  busy       out  1       1 in any state other than IDLE
//  grant_mem  out  1       owner of the current transaction: 1 MEM, 0 IF
//  err_rw     out  1       sticky; set when MEM is granted with mem_re & mem_we both high
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, starve_cnt=0, kill_pend=0.
//  FSM states: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//   - Arbitrate on each edge. MEM wins when (mem_re|mem_we) is set and NOT (if_re & starve_cnt==STARVE_MAX).
//   - Otherwise IF wins if if_re is set.
//   - On a grant: latch addr/len/wdata/owner into registers; go to BUSY.
//   - ram_re/ram_we are 1 from the first BUSY cycle. Request-to-strobe latency is 1 cycle.
//   - For a MEM grant: ram_we=mem_we and ram_re=~mem_we. Write wins, and err_rw is set if both were high.
//  BUSY:
//   - ram_* outputs are held stable until ram_ack.
//   - When ram_ack=1: drop ram_re/ram_we, capture ram_rdata, go to RESP.
//  RESP:
//   - Exactly one cycle with the owner's ack=1 and its data valid; then IDLE.
//   - Requester contract: the requester clears its re/we on the edge at which it samples ack=1.
//   - The arbiter therefore never re-grants a completed request.
//  Write ack: mem_ack pulses in RESP; mem_rdata is don't-care.
//  Starvation counter:
//   - starve_cnt += 1 (saturating at STARVE_MAX) on each MEM grant made while if_re=1.
//   - Cleared on an IF grant, or in any IDLE cycle with if_re=0.
//  Kill:
//   - if_kill=1 while the IF owns BUSY or RESP sets kill_pend.
//   - With kill_pend set, the IF transaction completes on the ram side, but if_rack is suppressed in RESP.
//   - kill_pend clears on leaving RESP.
//   - if_kill in IDLE blocks an IF grant that cycle only.
//   - The IF must deassert if_re within the kill cycle.
//  Ack stability: ram_ack seen in IDLE or RESP is ignored. A stale ack after reset must not start or complete anything.
//  Reset mid-transaction: immediate return to IDLE. ram_re/ram_we drop on that edge, and no ack is issued for the aborted access.
//  Outputs are registered only; there is no combinational path from any input to any output.
// TESTING
//  1 Lone IF read of 0x1000, ram_ack 2 cycles after ram_re -> ram_addr=0x1000, ram_len=3; if_rack is a single pulse with if_data=ram_rdata.
//  2 if_re and mem_we (addr 0x2000, data 0xDEADBEEF) raised in the same cycle -> MEM is granted first (ram_we=1, ram_wdata=0xDEADBEEF); IF is granted after mem_ack.
//  3 MEM requests back-to-back with if_re held, STARVE_MAX=4 -> 4 MEM grants, then 1 IF grant, then MEM again.
//  4 if_kill asserted during IF BUSY -> the ram access completes, no if_rack pulse, next grant is clean, kill_pend=0.
//  5 rst asserted while BUSY, then ram_ack arrives in IDLE -> outputs 0, no acks, FSM stays IDLE.
//  6 mem_re and mem_we both high -> write performed, err_rw=1 and stays set until rst.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM stage, MEM priority with IF anti-starvation.
// All outputs are registered; a kill during an IF access lets the ram side finish but drops the ack.
module mem_port_arbiter #(
    parameter int ADDR_L = 32,
    parameter int DATA_L = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_re,
    input  logic [ADDR_L-1:0] if_addr,
    input  logic [1:0]        if_rlen,
    input  logic              if_kill,
    output logic              if_rack,
    output logic [DATA_L-1:0] if_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_L-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [DATA_L-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_L-1:0] mem_rdata,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_L-1:0] ram_addr,
    output logic [1:0]        ram_len,
    output logic [DATA_L-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_L-1:0] ram_rdata,
    output logic              busy,
    output logic              grant_mem,
    output logic              err_rw
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state;
    logic [SW-1:0] starve_cnt;
    logic kill_pend, starved, mem_win, if_win;
    always_comb begin
        starved = if_re && starve_cnt == SW'(STARVE_MAX);
        mem_win = (mem_re || mem_we) && !starved;
        if_win = !mem_win && if_re && !if_kill;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            starve_cnt <= '0;
            kill_pend <= 1'b0;
            if_rack <= 1'b0;
            if_data <= '0;
            mem_ack <= 1'b0;
            mem_rdata <= '0;
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_len <= '0;
            ram_wdata <= '0;
            busy <= 1'b0;
            grant_mem <= 1'b0;
            err_rw <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_win || if_win) begin
                        state <= BUSY;
                        busy <= 1'b1;
                        grant_mem <= mem_win;
                        ram_addr <= mem_win ? mem_addr : if_addr;
                        ram_len <= mem_win ? mem_len : if_rlen;
                        ram_wdata <= mem_wdata;
                        ram_re <= !mem_win || !mem_we;
                        ram_we <= mem_win && mem_we;
                    end
                    if (mem_win && mem_re && mem_we)
                        err_rw <= 1'b1;
                    // counts only MEM grants that made a waiting IF fetch stand aside
                    if (if_win || !if_re)
                        starve_cnt <= '0;
                    else if (mem_win && !starved)
                        starve_cnt <= starve_cnt + SW'(1);
                end
                BUSY: begin
                    if (!grant_mem && if_kill)
                        kill_pend <= 1'b1;
                    if (ram_ack) begin
                        state <= RESP;
                        ram_re <= 1'b0;
                        ram_we <= 1'b0;
                        mem_ack <= grant_mem;
                        if_rack <= !grant_mem && !kill_pend && !if_kill;
                        if (grant_mem)
                            mem_rdata <= ram_rdata;
                        else
                            if_data <= ram_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    mem_ack <= 1'b0;
                    if_rack <= 1'b0;
                    kill_pend <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic if_re = 0, if_kill = 0, mem_re = 0, mem_we = 0, ram_ack = 0;
    logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, ram_rdata = 0;
    logic [1:0] if_rlen = 0, mem_len = 0;
    logic if_rack, mem_ack, ram_re, ram_we, busy, grant_mem, err_rw;
    logic [31:0] if_data, mem_rdata, ram_addr, ram_wdata;
    logic [1:0] ram_len;

    mem_port_arbiter #(.ADDR_L(32), .DATA_L(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_re(if_re), .if_addr(if_addr), .if_rlen(if_rlen), .if_kill(if_kill),
        .if_rack(if_rack), .if_data(if_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_len(ram_len),
        .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .busy(busy), .grant_mem(grant_mem), .err_rw(err_rw)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, rack_cnt = 0, mack_cnt = 0, lat = 1, rcnt = 0;
    int r0, m0, g0;
    int grants[$];
    logic man_ack = 0, mem_hold = 0, last_busy = 0;
    logic [31:0] last_ifd = 0, last_mrd = 0;

    // reference model: one transaction at a time, owner/phase tracked as plain flags
    bit m_act = 0, m_done = 0, m_kill = 0;
    int m_starve = 0;
    logic e_re = 0, e_we = 0, e_busy = 0, e_gm = 0, e_err = 0, e_rack = 0, e_mack = 0, e_mrdv = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_ifd = 0, e_mrd = 0;
    logic [1:0] e_len = 0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        if (rst) begin
            m_act = 0; m_done = 0; m_kill = 0; m_starve = 0;
            e_re = 0; e_we = 0; e_busy = 0; e_gm = 0; e_err = 0; e_rack = 0; e_mack = 0; e_mrdv = 0;
        end else if (!m_act) begin
            if ((mem_re || mem_we) && !(if_re && m_starve == SM)) begin
                m_act = 1; e_busy = 1; e_gm = 1;
                e_addr = mem_addr; e_len = mem_len; e_wd = mem_wdata;
                e_we = mem_we; e_re = !mem_we; e_mrdv = !mem_we;
                if (mem_re && mem_we) e_err = 1;
                m_starve = if_re ? (m_starve < SM ? m_starve + 1 : SM) : 0;
            end else if (if_re && !if_kill) begin
                m_act = 1; e_busy = 1; e_gm = 0;
                e_addr = if_addr; e_len = if_rlen; e_re = 1; e_we = 0; e_mrdv = 0;
                m_starve = 0;
            end else if (!if_re) begin
                m_starve = 0;
            end
        end else if (m_done) begin
            m_act = 0; m_done = 0; m_kill = 0; e_busy = 0; e_rack = 0; e_mack = 0;
        end else begin
            if (!e_gm && if_kill) m_kill = 1;
            if (ram_ack) begin
                m_done = 1; e_re = 0; e_we = 0;
                if (e_gm) begin
                    e_mack = 1; e_mrd = ram_rdata;
                end else if (!m_kill) begin
                    e_rack = 1; e_ifd = ram_rdata;
                end
            end
        end
    endtask

    task automatic compare_all();
        cmp("busy", busy, e_busy);
        cmp("ram_re", ram_re, e_re);
        cmp("ram_we", ram_we, e_we);
        cmp("if_rack", if_rack, e_rack);
        cmp("mem_ack", mem_ack, e_mack);
        cmp("err_rw", err_rw, e_err);
        if (e_busy) begin
            cmp("grant_mem", grant_mem, e_gm);
            cmp("ram_addr", ram_addr, e_addr);
            cmp("ram_len", ram_len, e_len);
        end
        if (e_we) cmp("ram_wdata", ram_wdata, e_wd);
        if (e_rack) cmp("if_data", if_data, e_ifd);
        if (e_mack && e_mrdv) cmp("mem_rdata", mem_rdata, e_mrd);
    endtask

    // one clock: check at negedge, update model at posedge, drive requesters and ram #1 later
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            logic rk, mk, sb;
            @(negedge clk);
            compare_all();
            rk = if_rack; mk = mem_ack; sb = ram_re | ram_we;
            if (rk) begin rack_cnt++; last_ifd = if_data; end
            if (mk) begin mack_cnt++; last_mrd = mem_rdata; end
            if (busy && !last_busy) grants.push_back(int'(grant_mem));
            last_busy = busy;
            if (sb && !ram_ack) rcnt++;
            @(posedge clk);
            model_tick();
            #1;
            if (rk) if_re = 0;
            if (mk && !mem_hold) begin mem_re = 0; mem_we = 0; end
            if (rst || ram_ack) rcnt = 0;
            ram_ack = (rcnt == lat) | man_ack;
        end
    endtask

    initial begin
        step(2);
        rst = 0;
        cmp("rst_busy", busy, 0);
        cmp("rst_ram_re", ram_re, 0);
        cmp("rst_if_rack", if_rack, 0);
        cmp("rst_err", err_rw, 0);

        // lone IF read, ram acks two cycles after the strobe
        lat = 2; ram_rdata = 32'hCAFE0001;
        if_re = 1; if_addr = 32'h1000; if_rlen = 3;
        step(1);
        cmp("t1_ram_re", ram_re, 1);
        cmp("t1_ram_addr", ram_addr, 32'h1000);
        cmp("t1_ram_len", ram_len, 3);
        step(6);
        cmp("t1_rack_cnt", rack_cnt, 1);
        cmp("t1_if_data", last_ifd, 32'hCAFE0001);
        cmp("t1_idle", busy, 0);

        // simultaneous IF read and MEM write: MEM first
        lat = 1; ram_rdata = 32'h11112222;
        g0 = grants.size();
        mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_len = 3;
        if_re = 1; if_addr = 32'h1004;
        step(1);
        cmp("t2_ram_we", ram_we, 1);
        cmp("t2_ram_re", ram_re, 0);
        cmp("t2_wdata", ram_wdata, 32'hDEADBEEF);
        cmp("t2_grant_mem", grant_mem, 1);
        step(10);
        cmp("t2_mack_cnt", mack_cnt, 1);
        cmp("t2_rack_cnt", rack_cnt, 2);
        cmp("t2_ngrants", grants.size(), g0 + 2);
        if (grants.size() >= g0 + 2) begin
            cmp("t2_first", grants[g0], 1);
            cmp("t2_second", grants[g0 + 1], 0);
        end

        // MEM read returns data
        ram_rdata = 32'hA5A55A5A; mem_re = 1; mem_addr = 32'h6000; mem_len = 1;
        step(6);
        cmp("t2b_mack_cnt", mack_cnt, 2);
        cmp("t2b_mrdata", last_mrd, 32'hA5A55A5A);

        // back-to-back MEM with IF waiting: four MEM grants, one IF, then MEM
        g0 = grants.size(); r0 = rack_cnt;
        mem_hold = 1; mem_re = 1; mem_addr = 32'h7000;
        if_re = 1; if_addr = 32'h1008;
        step(30);
        mem_hold = 0; mem_re = 0;
        step(8);
        cmp("t3_rack", rack_cnt, r0 + 1);
        cmp("t3_ngrants", grants.size() >= g0 + 6, 1);
        if (grants.size() >= g0 + 6) begin
            cmp("t3_g0", grants[g0], 1);
            cmp("t3_g3", grants[g0 + 3], 1);
            cmp("t3_g4", grants[g0 + 4], 0);
            cmp("t3_g5", grants[g0 + 5], 1);
        end

        // kill during IF BUSY: access completes, no ack
        lat = 3; r0 = rack_cnt; ram_rdata = 32'h99990000;
        if_re = 1; if_addr = 32'h3000;
        step(2);
        if_kill = 1; if_re = 0;
        step(1);
        if_kill = 0;
        step(8);
        cmp("t4_no_rack", rack_cnt, r0);
        cmp("t4_idle", busy, 0);
        lat = 1; ram_rdata = 32'h0BADF00D;
        if_re = 1; if_addr = 32'h3004;
        step(7);
        cmp("t4_clean_rack", rack_cnt, r0 + 1);
        cmp("t4_clean_data", last_ifd, 32'h0BADF00D);
        // kill in IDLE holds off the grant for that cycle only
        if_re = 1; if_kill = 1;
        step(1);
        cmp("t4_kill_idle", busy, 0);
        if_kill = 0;
        step(1);
        cmp("t4_after_kill", busy, 1);
        step(6);
        cmp("t4_rack2", rack_cnt, r0 + 2);

        // reset mid-transaction, then a stale ack in IDLE
        lat = 5; m0 = mack_cnt; r0 = rack_cnt;
        mem_re = 1; mem_addr = 32'h4000;
        step(2);
        cmp("t5_strobe", ram_re, 1);
        rst = 1; mem_re = 0;
        step(1);
        rst = 0;
        cmp("t5_busy", busy, 0);
        cmp("t5_ram_re", ram_re, 0);
        man_ack = 1;
        step(1);
        man_ack = 0;
        step(4);
        cmp("t5_no_mack", mack_cnt, m0);
        cmp("t5_no_rack", rack_cnt, r0);
        cmp("t5_still_idle", busy, 0);

        // read+write together: write wins, err_rw sticky until reset
        lat = 1; m0 = mack_cnt;
        mem_re = 1; mem_we = 1; mem_addr = 32'h5000; mem_wdata = 32'h12345678;
        step(1);
        cmp("t6_ram_we", ram_we, 1);
        cmp("t6_ram_re", ram_re, 0);
        cmp("t6_err", err_rw, 1);
        cmp("t6_wdata", ram_wdata, 32'h12345678);
        step(6);
        cmp("t6_mack", mack_cnt, m0 + 1);
        if_re = 1; if_addr = 32'h100;
        step(6);
        cmp("t6_err_sticky", err_rw, 1);
        rst = 1;
        step(1);
        rst = 0;
        cmp("t6_err_cleared", err_rw, 0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
